program_counter: RTL and testbench
==================================

# program_counter

Hack-platform program counter: a WIDTH-bit register that resets, loads a jump target, increments, or holds on each clock edge. It sits directly downstream of the combinational gate layer (Not/And/Mux) that forms the CPU's jump-condition logic, consuming the resolved load/inc decision, and drives the instruction ROM address. An optional detector flags the Hack "end-of-program" tight loop so benches can stop the simulation deterministically.

## Interface
- WIDTH, 16, counter/address width in bits.
- HALT_LOOPS, 2, consecutive tight-loop jumps required to assert halt_o; legal range 1..15.

- clk_i  input  1  single clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- in_i  input  WIDTH  jump target.
- load_i  input  1  load in_i into counter.
- inc_i  input  1  increment counter.
- out_o  output  WIDTH  current PC value (registered).
- halt_o  output  1  sticky tight-loop-detected flag (registered).

## Operation
- Next-state priority per edge: rst_i > load_i > inc_i > hold.
  - rst_i: out_o <= 0, detector cleared to RUN, count 0, halt_o <= 0.
  - load_i: out_o <= in_i (inc_i ignored).
  - inc_i: out_o <= out_o + 1, modulo 2^WIDTH (all-ones wraps to 0, no flag).
  - neither: out_o holds.
- Tight-loop jump: a cycle with load_i=1, rst_i=0, and in_i == out_o or in_i == out_o - 1 (unsigned; out_o=0 with in_i=all-ones is NOT a tight loop, no wrap in the compare).
- Detector FSM (3 states), count is a 4-bit saturating counter:
  - RUN: tight-loop jump -> count <= 1, go ARMED (go directly to HALTED if HALT_LOOPS=1).
  - ARMED: tight-loop jump -> count+1; when count+1 == HALT_LOOPS go HALTED. Non-tight load -> count <= 0, RUN. Inc-only or hold cycles -> no change.
  - HALTED: halt_o=1; stays until rst_i. Counter keeps operating normally; halt_o does not freeze it.
- halt_o is a registered decode of state==HALTED.

## Timing
- out_o and halt_o change only on the rising edge; zero combinational path from any input to any output.
- Latency: load/inc/reset visible on out_o one cycle after the sampling edge.
- halt_o rises on the same edge that performs the HALT_LOOPS-th tight-loop jump.
- Reset values: out_o=0, halt_o=0, FSM=RUN, count=0. Reset asserted mid-operation (any state, any load/inc) wins on that edge; first post-reset update occurs the edge after rst_i deasserts.
- Inputs are sampled only at the edge; glitches between edges are irrelevant.

## Configuration
- PC_HALT_DETECT_EN defined: detector FSM and count are compiled in; halt_o behaves as above.
- Not defined: FSM and count are absent; halt_o tied to constant 0; counter behaviour, priorities and timing unchanged.

## Test plan
- Reset/priority: rst_i=1 with load_i=1, in_i=16'h1234, inc_i=1 -> next out_o=0, halt_o=0; then load_i=1, inc_i=1, in_i=16'h00A0 -> out_o=16'h00A0.
- Increment and wrap: load 16'hFFFE, then inc_i=1 for 3 cycles -> out_o 16'hFFFF, 16'h0000, 16'h0001; hold (both low) 2 cycles -> stays 16'h0001.
- Hack END loop (macro on, HALT_LOOPS=2): load 16'h0010, inc -> 16'h0011, load 16'h0010 (tight #1, halt_o=0), inc, load 16'h0010 (tight #2) -> halt_o=1 on that edge; further inc -> out_o=16'h0011, halt_o stays 1.
- Broken loop: one tight jump to 16'h0010 from 16'h0011, then load 16'h0040 from 16'h0010 -> count cleared; next single tight jump -> halt_o remains 0.
- No-wrap compare: out_o=0, load_i=1, in_i=16'hFFFF repeated 4 times -> halt_o=0; jump to self at 16'h0005 twice -> halt_o=1; rst_i pulse -> out_o=0, halt_o=0.
- Macro off: rerun the END-loop scenario -> out_o sequence identical, halt_o=0 throughout.

Source files
------------

// File: rtl/program_counter.sv
// program_counter
//
// Hack-platform program counter. A WIDTH-bit register that, on each rising
// edge, resets, loads a jump target, increments, or holds. It consumes the
// resolved load/inc decision from the CPU jump-condition gates and drives the
// instruction ROM address.
//
// Optional end-of-program detector (compiled in when PC_HALT_DETECT_EN is
// defined): flags the Hack tight loop (a jump to the current or the previous
// address) once HALT_LOOPS consecutive tight-loop jumps have been seen. Without
// the macro, halt_o is constant 0 and the counter behaves identically.
//
// Parameters:
//   WIDTH       counter/address width in bits (default 16)
//   HALT_LOOPS  tight-loop jumps required to raise halt_o, legal 1..15
//
// Ports:
//   clk_i   in   1      clock, all state updates on the rising edge
//   rst_i   in   1      synchronous active-high reset
//   in_i    in   WIDTH  jump target
//   load_i  in   1      load in_i into the counter (wins over inc_i)
//   inc_i   in   1      increment the counter (wraps modulo 2^WIDTH)
//   out_o   out  WIDTH  current PC value (registered)
//   halt_o  out  1      sticky tight-loop-detected flag (registered)
//
// Control semantics: there is no handshake; load_i/inc_i are sampled on every
// rising edge with priority rst_i > load_i > inc_i > hold.

module program_counter #(
  parameter int WIDTH      = 16,
  parameter int HALT_LOOPS = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] out_o,
  output logic             halt_o
);

  // Counter datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_o <= '0;
    end else if (load_i) begin
      out_o <= in_i;
    end else if (inc_i) begin
      out_o <= out_o + 1'b1;
    end
  end

`ifdef PC_HALT_DETECT_EN

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ARMED  = 2'd1,
    HALTED = 2'd2
  } det_state_t;

  localparam logic [3:0] HALT_CNT = 4'(HALT_LOOPS);

  det_state_t state;
  logic [3:0] count;
  logic [3:0] count_inc;
  logic       tight;

  // Jump to self or to the previous address. The "previous" case is
  // suppressed at address 0 so that 0 -> all-ones is not treated as a loop.
  always_comb begin
    tight = 1'b0;
    if (load_i) begin
      if (in_i == out_o) begin
        tight = 1'b1;
      end else if ((out_o != '0) && (in_i == (out_o - 1'b1))) begin
        tight = 1'b1;
      end
    end
  end

  // Saturating increment of the loop counter
  assign count_inc = (count == 4'hF) ? count : (count + 4'd1);

  // halt_o is updated alongside state so it always equals (state == HALTED)
  // as seen after the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= RUN;
      count  <= 4'd0;
      halt_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (tight) begin
            count <= 4'd1;
            if (HALT_CNT == 4'd1) begin
              state  <= HALTED;
              halt_o <= 1'b1;
            end else begin
              state <= ARMED;
            end
          end
        end
        ARMED: begin
          if (tight) begin
            count <= count_inc;
            if (count_inc == HALT_CNT) begin
              state  <= HALTED;
              halt_o <= 1'b1;
            end
          end else if (load_i) begin
            count <= 4'd0;
            state <= RUN;
          end
        end
        HALTED: begin
          halt_o <= 1'b1;
        end
        default: begin
          state  <= RUN;
          count  <= 4'd0;
          halt_o <= 1'b0;
        end
      endcase
    end
  end

`else

  localparam bit unused_halt_loops = (HALT_LOOPS > 0);

  assign halt_o = 1'b0;

`endif

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter
//
// Directed-vector bench for program_counter (WIDTH=16, HALT_LOOPS=2).
// Expected values are hand-computed. halt_o expectations follow whether
// PC_HALT_DETECT_EN is defined for the build; without it halt_o must be 0.

module tb_program_counter;

`ifdef PC_HALT_DETECT_EN
  localparam bit DET = 1'b1;
`else
  localparam bit DET = 1'b0;
`endif

  logic        clk_i;
  logic        rst_i;
  logic [15:0] in_i;
  logic        load_i;
  logic        inc_i;
  logic [15:0] out_o;
  logic        halt_o;

  int n_vec;
  int n_err;

  program_counter #(
    .WIDTH      (16),
    .HALT_LOOPS (2)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .in_i   (in_i),
    .load_i (load_i),
    .inc_i  (inc_i),
    .out_o  (out_o),
    .halt_o (halt_o)
  );

  // Clock / reset block
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    rst_i  = 1'b1;
    in_i   = 16'h0000;
    load_i = 1'b0;
    inc_i  = 1'b0;
  end

  // Checker
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver: apply inputs, wait for one rising edge, settle 1 time unit.
  task automatic cyc(input logic r, input logic l, input logic i, input logic [15:0] d);
    rst_i  = r;
    load_i = l;
    inc_i  = i;
    in_i   = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_pc(input string tag, input logic [15:0] pc, input logic h);
    check({tag, "_pc"}, out_o, pc);
    check({tag, "_halt"}, {15'd0, halt_o}, {15'd0, h});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    @(posedge clk_i);
    #1;

    // Reset/priority
    cyc(1, 1, 1, 16'h1234); expect_pc("rst_pri", 16'h0000, 1'b0);
    cyc(0, 1, 1, 16'h00A0); expect_pc("load_pri", 16'h00A0, 1'b0);

    // Increment and wrap, then hold
    cyc(0, 1, 0, 16'hFFFE); expect_pc("load_fffe", 16'hFFFE, 1'b0);
    cyc(0, 0, 1, 16'h0000); expect_pc("inc1", 16'hFFFF, 1'b0);
    cyc(0, 0, 1, 16'h0000); expect_pc("wrap", 16'h0000, 1'b0);
    cyc(0, 0, 1, 16'h0000); expect_pc("inc3", 16'h0001, 1'b0);
    cyc(0, 0, 0, 16'h5555); expect_pc("hold1", 16'h0001, 1'b0);
    cyc(0, 0, 0, 16'hAAAA); expect_pc("hold2", 16'h0001, 1'b0);

    // Hack END loop
    cyc(0, 1, 0, 16'h0010); expect_pc("end_ld", 16'h0010, 1'b0);
    cyc(0, 0, 1, 16'h0000); expect_pc("end_inc1", 16'h0011, 1'b0);
    cyc(0, 1, 0, 16'h0010); expect_pc("end_tight1", 16'h0010, 1'b0);
    cyc(0, 0, 1, 16'h0000); expect_pc("end_inc2", 16'h0011, 1'b0);
    cyc(0, 1, 0, 16'h0010); expect_pc("end_tight2", 16'h0010, DET);
    cyc(0, 0, 1, 16'h0000); expect_pc("end_inc3", 16'h0011, DET);
    cyc(0, 0, 1, 16'h0000); expect_pc("end_inc4", 16'h0012, DET);
    cyc(0, 1, 0, 16'h0100); expect_pc("end_sticky", 16'h0100, DET);
    cyc(0, 0, 0, 16'h0000); expect_pc("end_hold", 16'h0100, DET);

    // Mid-operation reset clears halt
    cyc(1, 0, 1, 16'h0000); expect_pc("rst2", 16'h0000, 1'b0);

    // Broken loop
    cyc(0, 1, 0, 16'h0011); expect_pc("brk_ld", 16'h0011, 1'b0);
    cyc(0, 1, 0, 16'h0010); expect_pc("brk_tight", 16'h0010, 1'b0);
    cyc(0, 1, 0, 16'h0040); expect_pc("brk_far", 16'h0040, 1'b0);
    cyc(0, 1, 0, 16'h0040); expect_pc("brk_tight2", 16'h0040, 1'b0);

    // No-wrap compare: 0 -> FFFF is not a tight loop
    cyc(1, 0, 0, 16'h0000); expect_pc("rst3", 16'h0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 16'hFFFF); expect_pc("nowrap_ff", 16'hFFFF, 1'b0);
      cyc(0, 1, 0, 16'h0000); expect_pc("nowrap_00", 16'h0000, 1'b0);
    end

    // Jump to self twice
    cyc(0, 1, 0, 16'h0005); expect_pc("self_ld", 16'h0005, 1'b0);
    cyc(0, 1, 0, 16'h0005); expect_pc("self1", 16'h0005, 1'b0);
    cyc(0, 1, 0, 16'h0005); expect_pc("self2", 16'h0005, DET);

    // Reset pulse with load/inc asserted
    cyc(1, 1, 1, 16'h7777); expect_pc("rst4", 16'h0000, 1'b0);
    cyc(0, 0, 1, 16'h0000); expect_pc("post_rst_inc", 16'h0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
